// File: rtl/snow64_instr_fetch.sv
// Snow64 instruction fetch: owns the PC, issues one icache read at a time,
// and buffers returned instructions (tagged with their PC) for decode.
module snow64_instr_fetch #(
  parameter int unsigned            WIDTH__ADDR  = 64,
  parameter int unsigned            WIDTH__INSTR = 32,
  parameter int unsigned            FIFO_DEPTH   = 4,
  parameter logic [WIDTH__ADDR-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    out_icache_req,
  output logic [WIDTH__ADDR-1:0]  out_icache_addr,
  input  logic                    in_icache_valid,
  input  logic [WIDTH__INSTR-1:0] in_icache_instr,
  input  logic                    in_redirect_valid,
  input  logic [WIDTH__ADDR-1:0]  in_redirect_addr,
  input  logic                    in_decode_ready,
  output logic                    out_decode_valid,
  output logic [WIDTH__INSTR-1:0] out_decode_instr,
  output logic [WIDTH__ADDR-1:0]  out_decode_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_WAIT,
    ST_WAIT_DISCARD
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH__ADDR-1:0]  pc_q, pc_d;
  logic                    req_q;
  logic [WIDTH__ADDR-1:0]  addr_q;

  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [WIDTH__INSTR-1:0] instr_mem_q [FIFO_DEPTH];
  logic [WIDTH__ADDR-1:0]  pc_mem_q    [FIFO_DEPTH];

  logic issue, push, pop, fifo_empty;

  // Control decode, next PC and next FSM state
  always_comb begin
    fifo_empty = (count_q == '0);
    // Only ST_ISSUE can issue, so nothing is outstanding and the credit is the FIFO space.
    issue = (state_q == ST_ISSUE) && !in_redirect_valid && (count_q < DEPTH_C);
    push  = (state_q == ST_WAIT) && in_icache_valid && !in_redirect_valid;
    pop   = !fifo_empty && in_decode_ready;

    pc_d = pc_q;
    if (in_redirect_valid) begin
      pc_d = {in_redirect_addr[WIDTH__ADDR-1:2], 2'b00};
    end else if (push) begin
      pc_d = pc_q + WIDTH__ADDR'(4);
    end

    state_d = state_q;
    case (state_q)
      ST_ISSUE: begin
        if (issue) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (in_icache_valid)        state_d = ST_ISSUE;
        else if (in_redirect_valid) state_d = ST_WAIT_DISCARD;
      end
      // A response arriving here is the one being discarded, even if a new
      // redirect lands in the same cycle; otherwise stay until it shows up.
      ST_WAIT_DISCARD: begin
        if (in_icache_valid) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FSM, PC and registered icache request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      // An outstanding request survives reset unless its response lands this very cycle.
      state_q <= ((state_q != ST_ISSUE) && !in_icache_valid) ? ST_WAIT_DISCARD : ST_ISSUE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= issue;
      if (issue) addr_q <= pc_q;
    end
  end

  // FIFO pointers and occupancy; redirect flush overrides push/pop
  always_ff @(posedge clk) begin
    if (rst || in_redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= in_icache_instr;
      pc_mem_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign out_icache_req   = req_q;
  assign out_icache_addr  = addr_q;
  assign out_decode_valid = !fifo_empty;
  assign out_decode_instr = fifo_empty ? '0 : instr_mem_q[rd_ptr_q];
  assign out_decode_pc    = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_snow64_instr_fetch.sv
// Bench for snow64_instr_fetch: queue-based fetch model plus a small icache
// responder, directed scenarios followed by random traffic.
module tb_snow64_instr_fetch;

  localparam int unsigned DEPTH   = 4;
  localparam logic [63:0] RST_PC  = 64'h1000;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_req;
  logic [63:0] ic_addr;
  logic        ic_valid = 1'b0;
  logic [31:0] ic_instr = '0;
  logic        redir = 1'b0;
  logic [63:0] raddr = '0;
  logic        rdy = 1'b0;
  logic        dvalid;
  logic [31:0] dinstr;
  logic [63:0] dpc;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_valid = 1'b0;
  logic [31:0] w_instr = '0;
  logic        w_redir = 1'b0;
  logic [63:0] w_raddr = '0;
  logic        w_rdy = 1'b0;
  logic        w_dvalid;
  logic [31:0] w_dinstr;
  logic [63:0] w_dpc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snow64_instr_fetch #(
    .WIDTH__ADDR(64), .WIDTH__INSTR(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .out_icache_req(ic_req), .out_icache_addr(ic_addr),
    .in_icache_valid(ic_valid), .in_icache_instr(ic_instr),
    .in_redirect_valid(redir), .in_redirect_addr(raddr),
    .in_decode_ready(rdy),
    .out_decode_valid(dvalid), .out_decode_instr(dinstr), .out_decode_pc(dpc)
  );

  snow64_instr_fetch #(
    .WIDTH__ADDR(64), .WIDTH__INSTR(32), .FIFO_DEPTH(DEPTH), .RESET_PC(WRAP_PC)
  ) dut_wrap (
    .clk(clk), .rst(rst),
    .out_icache_req(w_req), .out_icache_addr(w_addr),
    .in_icache_valid(w_valid), .in_icache_instr(w_instr),
    .in_redirect_valid(w_redir), .in_redirect_addr(w_raddr),
    .in_decode_ready(w_rdy),
    .out_decode_valid(w_dvalid), .out_decode_instr(w_dinstr), .out_decode_pc(w_dpc)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: fetch buffer as a queue of {instr, pc}
  logic [63:0] m_pc = RST_PC;
  logic [95:0] m_q[$];
  bit          m_out = 0, m_disc = 0, m_req = 0, m_rst_last = 1;
  logic [63:0] m_addr = '0;

  bit          chk_en = 0;
  bit          ic_pend = 0;
  int unsigned ic_cnt = 0;
  int unsigned lat = 1;
  bit          spur_en = 0;
  bit          w_done = 0;

  task automatic model_step(input bit r, input bit v, input logic [31:0] ins,
                            input bit rd, input logic [63:0] ra, input bit rd_y);
    bit nreq;
    m_rst_last = r;
    if (r) begin
      m_disc = m_out && !v;
      m_out  = m_out && !v;
      m_q.delete();
      m_pc   = RST_PC;
      m_req  = 0;
      m_addr = '0;
    end else begin
      nreq = !m_out && !rd && (m_q.size() < DEPTH);
      if (rd) begin
        m_q.delete();
        m_pc = {ra[63:2], 2'b00};
        if (m_out) begin
          if (v) begin m_out = 0; m_disc = 0; end
          else m_disc = 1;
        end
      end else begin
        if (m_q.size() != 0 && rd_y) void'(m_q.pop_front());
        if (m_out && v) begin
          if (!m_disc) begin
            m_q.push_back({ins, m_pc});
            m_pc = m_pc + 64'd4;
          end
          m_out = 0;
          m_disc = 0;
        end
      end
      if (nreq) begin
        m_out  = 1;
        m_addr = m_pc;
      end
      m_req = nreq;
    end
  endtask

  // One clock: check outputs, run icache responder, drive inputs, advance model
  task automatic cycle(input bit r, input bit rd, input logic [63:0] ra, input bit rd_y);
    bit v;
    logic [31:0] ins;
    @(negedge clk);
    if (chk_en) begin
      chk("req", ic_req, m_req);
      if (m_req || m_rst_last) chk("addr", ic_addr, m_addr);
      chk("dvalid", dvalid, m_q.size() != 0);
      if (m_q.size() != 0) begin
        chk("dinstr", dinstr, m_q[0][95:64]);
        chk("dpc", dpc, m_q[0][63:0]);
      end else if (m_rst_last) begin
        chk("dinstr_rst", dinstr, 0);
        chk("dpc_rst", dpc, 0);
      end
    end
    v = 0;
    if (ic_pend) begin
      ic_cnt--;
      if (ic_cnt == 0) begin v = 1; ic_pend = 0; end
    end
    if (ic_req === 1'b1) begin
      ic_pend = 1;
      ic_cnt  = lat;
    end else if (spur_en && !ic_pend && !m_out && $urandom_range(0, 15) == 0) begin
      v = 1;
    end
    ins = $urandom;
    rst = r; ic_valid = v; ic_instr = ins; redir = rd; raddr = ra; rdy = rd_y;
    model_step(r, v, ins, rd, ra, rd_y);
  endtask

  // kind 0: a request is outstanding; kind 1: icache answers in the next cycle
  task automatic run_until(input int unsigned kind, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if ((kind == 0 && m_out && !m_disc) || (kind == 1 && ic_pend && ic_cnt == 1)) begin
        found = 1;
        break;
      end
      cycle(0, 0, '0, 1);
    end
    chk(tag, found, 1);
  endtask

  // Wrap instance: PC just below 2^64 must roll over to 0
  initial begin : wrap_test
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (w_req === 1'b1 && rst === 1'b0) seen = 1;
    end
    chk("w_first_req", seen, 1);
    chk("w_addr0", w_addr, WRAP_PC);
    @(negedge clk);
    w_valid = 1'b1;
    w_instr = 32'hCAFE_0001;
    @(negedge clk);
    w_valid = 1'b0;
    chk("w_dvalid", w_dvalid, 1);
    chk("w_dpc", w_dpc, WRAP_PC);
    chk("w_dinstr", w_dinstr, 32'hCAFE_0001);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (w_req === 1'b1) seen = 1;
      else @(negedge clk);
    end
    chk("w_second_req", seen, 1);
    chk("w_addr1", w_addr, 64'h0);
    w_done = 1;
  end

  initial begin : main
    bit          r, rd, rd_y;
    logic [63:0] ra;

    cycle(1, 0, '0, 1);
    chk_en = 1;
    cycle(1, 0, '0, 1);

    // Straight-line fetch, decode always ready
    lat = 1;
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

    // Decode stalled: buffer fills to depth and issue stops
    for (int i = 0; i < 40; i++) cycle(0, 0, '0, 0);
    chk("fifo_full", m_q.size(), DEPTH);
    cycle(0, 0, '0, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);

    // Redirect while waiting; late response must be discarded
    lat = 3;
    run_until(0, "wait_outstanding_a");
    cycle(0, 1, 64'h2002, 1);
    for (int i = 0; i < 15; i++) cycle(0, 0, '0, 1);

    // Redirect in the same cycle as the response
    lat = 2;
    run_until(1, "wait_resp_edge");
    cycle(0, 1, 64'h2000, 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, '0, 1);

    // Reset with a request in flight; response arrives after reset
    lat = 3;
    run_until(0, "wait_outstanding_b");
    cycle(1, 0, '0, 1);
    cycle(1, 0, '0, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, '0, 1);

    // Random traffic
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      lat  = $urandom_range(1, 3);
      r    = ($urandom_range(0, 299) == 0);
      rd   = ($urandom_range(0, 11) == 0);
      ra   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = 64'h2000 + 64'($urandom_range(0, 3));
      rd_y = ((i % 128) < 40) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cycle(r, rd, ra, rd_y);
    end
    cycle(0, 0, '0, 1);

    for (int i = 0; i < 100 && !w_done; i++) @(negedge clk);
    chk("wrap_done", w_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
